// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction, ALU, condition and status codes.
package y86_pkg;

    localparam int W = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [2:0] CC_RST = 3'b100;

    typedef struct packed {
        logic [2:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
    } m_bundle_t;

    localparam m_bundle_t M_RST = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0,
                                    valE: '0, valA: '0, dstE: RNONE, dstM: RNONE};

    // cc is packed {ZF,SF,OF}
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (fn)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// E-stage input bundle, pipeline control, forwarding outputs and the registered M bundle.
interface execute_stage_if;

    logic [2:0]            E_stat;
    logic [3:0]            E_icode;
    logic [3:0]            E_ifun;
    logic [y86_pkg::W-1:0] E_valA;
    logic [y86_pkg::W-1:0] E_valB;
    logic [y86_pkg::W-1:0] E_valC;
    logic [3:0]            E_dstE;
    logic [3:0]            E_dstM;
    logic                  exc_pending;
    logic                  M_stall;
    logic                  M_bubble;

    logic [y86_pkg::W-1:0] e_valE;
    logic [3:0]            e_dstE;
    logic                  e_Cnd;
    logic [2:0]            M_stat;
    logic [3:0]            M_icode;
    logic                  M_Cnd;
    logic [y86_pkg::W-1:0] M_valE;
    logic [y86_pkg::W-1:0] M_valA;
    logic [3:0]            M_dstE;
    logic [3:0]            M_dstM;
    logic [2:0]            cc_out;

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output exc_pending, M_stall, M_bubble,
        input  e_valE, e_dstE, e_Cnd,
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  exc_pending, M_stall, M_bubble,
        output e_valE, e_dstE, e_Cnd,
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational 64-bit Y86 ALU: add/sub/and/xor with zero, sign and overflow flags.
module alu_64
    import y86_pkg::*;
(
    input  logic [3:0]   fun_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] val_o,
    output logic         zf_o,
    output logic         sf_o,
    output logic         of_o
);

    logic [W-1:0] val;
    logic         of;

    // operands follow the Y86 convention: result is B op A
    always_comb begin
        val = '0;
        of  = 1'b0;
        case (fun_i)
            ALU_ADD: begin
                val = b_i + a_i;
                of  = (a_i[W-1] == b_i[W-1]) && (val[W-1] != a_i[W-1]);
            end
            ALU_SUB: begin
                val = b_i - a_i;
                of  = (a_i[W-1] != b_i[W-1]) && (val[W-1] != b_i[W-1]);
            end
            ALU_AND: val = b_i & a_i;
            ALU_XOR: val = b_i ^ a_i;
            default: val = '0;
        endcase
    end

    assign val_o = val;
    assign of_o  = of;
    assign zf_o  = (val == '0);
    assign sf_o  = val[W-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, Cnd and the E->M pipeline register.
module execute_stage
    import y86_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    execute_stage_if.slave bus
);

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_fun;
    logic [W-1:0] alu_val;
    logic         alu_zf;
    logic         alu_sf;
    logic         alu_of;
    logic [2:0]   cc_q;
    logic [2:0]   cc_d;
    logic         cc_we;
    logic         cnd;
    logic [3:0]   dst_e;
    m_bundle_t    m_q;
    m_bundle_t    m_d;

    always_comb begin
        alu_a = '0;
        case (bus.E_icode)
            I_OPQ, I_RRMOVQ:           alu_a = bus.E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
            I_CALL, I_PUSHQ:           alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POPQ:             alu_a = 64'd8;
            default:                   alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (bus.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = bus.E_valB;
            default:                                                  alu_b = '0;
        endcase
    end

    assign alu_fun = (bus.E_icode == I_OPQ) ? bus.E_ifun : ALU_ADD;

    alu_64 u_alu (
        .fun_i (alu_fun),
        .a_i   (alu_a),
        .b_i   (alu_b),
        .val_o (alu_val),
        .zf_o  (alu_zf),
        .sf_o  (alu_sf),
        .of_o  (alu_of)
    );

    // CC write is independent of M_stall/M_bubble; only exceptions further down block it
    assign cc_we = (bus.E_icode == I_OPQ) && (bus.E_ifun <= ALU_XOR) &&
                   (bus.E_stat == S_AOK) && !bus.exc_pending;
    assign cc_d  = cc_we ? {alu_zf, alu_sf, alu_of} : cc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cc_q <= CC_RST;
        else     cc_q <= cc_d;
    end

    assign cnd   = cond_eval(bus.E_ifun, cc_q);
    assign dst_e = ((bus.E_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.E_dstE;

    always_comb begin
        m_d = m_q;
        if (bus.M_bubble) begin
            m_d = M_RST;
        end else if (!bus.M_stall) begin
            m_d.stat  = bus.E_stat;
            m_d.icode = bus.E_icode;
            m_d.cnd   = cnd;
            m_d.valE  = alu_val;
            m_d.valA  = bus.E_valA;
            m_d.dstE  = dst_e;
            m_d.dstM  = bus.E_dstM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_q <= M_RST;
        else     m_q <= m_d;
    end

    assign bus.e_valE  = alu_val;
    assign bus.e_dstE  = dst_e;
    assign bus.e_Cnd   = cnd;
    assign bus.M_stat  = m_q.stat;
    assign bus.M_icode = m_q.icode;
    assign bus.M_Cnd   = m_q.cnd;
    assign bus.M_valE  = m_q.valE;
    assign bus.M_valA  = m_q.valA;
    assign bus.M_dstE  = m_q.dstE;
    assign bus.M_dstM  = m_q.dstM;
    assign bus.cc_out  = cc_q;

endmodule
